// File: rtl/mod_counter_prog.sv
// Runtime-programmable modulo counter: writable modulo, up/down counting,
// parallel load with clamping, and a one-shot mode with START/DONE handshake.
// Optional macro MOD_COUNTER_PROG_TOGGLE_EN enables the divided square output
// on TGL; without it TGL is tied low and no toggle register exists.
module mod_counter_prog #(
   parameter int unsigned W              = 27,
   parameter int unsigned DEFAULT_MODULO = 100000000
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         CE,
   input  logic         CLR,
   input  logic         LOAD,
   input  logic [W-1:0] D,
   input  logic         MOD_WE,
   input  logic [W-1:0] MOD_D,
   input  logic         DIR,
   input  logic         ONESHOT,
   input  logic         START,
   output logic [W-1:0] Q,
   output logic         CO,
   output logic         BUSY,
   output logic         DONE,
   output logic         TGL
);

   localparam logic [W-1:0] ONE       = W'(1);
   localparam logic [W-1:0] MOD_RESET = W'(DEFAULT_MODULO);

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   state_t       state;
   state_t       state_next;
   logic [W-1:0] modulo;
   logic [W-1:0] term;
   logic [W-1:0] start_val;
   logic [W-1:0] mod_start;
   logic         gate;
   logic         mod_wr;
   logic         done_next;

   // Terminal/start values for the current direction, count gate and carry-out
   always_comb begin
      term      = DIR ? '0 : modulo - ONE;
      start_val = DIR ? modulo - ONE : '0;
      mod_start = DIR ? MOD_D - ONE : '0;
      mod_wr    = MOD_WE && (MOD_D != '0);
      gate      = CE && (!ONESHOT || (state == COUNT));
      CO        = gate && (Q == term);
   end

   // One-shot state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_next;
   end

   // One-shot next-state: start on strobe, end on carry, abort on clear or mode drop
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (START && ONESHOT && !CLR) state_next = COUNT;
         COUNT:   if (CLR || !ONESHOT || CO)    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // One-shot outputs: busy level and completion strobe for the DONE register
   always_comb begin
      BUSY      = (state == COUNT) && ONESHOT;
      done_next = (state == COUNT) && ONESHOT && CO && !CLR;
   end

   // Count and modulo registers; clear > modulo write > load > count
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         Q      <= '0;
         modulo <= MOD_RESET;
      end else if (CLR) begin
         Q      <= '0;
      end else if (mod_wr) begin
         modulo <= MOD_D;
         Q      <= mod_start;
      end else if (LOAD) begin
         Q      <= (D < modulo) ? D : modulo - ONE;
      end else if (gate) begin
         if (Q == term) Q <= start_val;
         else if (DIR)  Q <= Q - ONE;
         else           Q <= Q + ONE;
      end
   end

   // Single-cycle completion pulse
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) DONE <= 1'b0;
      else        DONE <= done_next;
   end

`ifdef MOD_COUNTER_PROG_TOGGLE_EN
   // Divided square wave: flips on every carry, cleared by CLR
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)   TGL <= 1'b0;
      else if (CLR) TGL <= 1'b0;
      else if (CO)  TGL <= ~TGL;
   end
`else
   assign TGL = 1'b0;
`endif

endmodule

// File: tb/tb_mod_counter_prog.sv
// Bench for mod_counter_prog (W=4, DEFAULT_MODULO=5): directed vectors,
// an integer reference model checked every falling edge, plus literal checks.
module tb_mod_counter_prog;

   localparam int unsigned W  = 4;
   localparam int          DM = 5;

   logic         CLK;
   logic         RST_N;
   logic         CE, CLR, LOAD, MOD_WE, DIR, ONESHOT, START;
   logic [W-1:0] D, MOD_D;
   logic [W-1:0] Q;
   logic         CO, BUSY, DONE, TGL;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int mq, mm, mrun, mdone, mtgl;

   mod_counter_prog #(.W(W), .DEFAULT_MODULO(DM)) dut (
      .CLK(CLK), .RST_N(RST_N), .CE(CE), .CLR(CLR), .LOAD(LOAD), .D(D),
      .MOD_WE(MOD_WE), .MOD_D(MOD_D), .DIR(DIR), .ONESHOT(ONESHOT),
      .START(START), .Q(Q), .CO(CO), .BUSY(BUSY), .DONE(DONE), .TGL(TGL)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   function automatic int model_gate();
      return (CE && (!ONESHOT || mrun != 0)) ? 1 : 0;
   endfunction

   function automatic int model_co();
      int t;
      t = DIR ? 0 : mm - 1;
      return (model_gate() != 0 && mq == t) ? 1 : 0;
   endfunction

   // reference model: advance one edge using the spec's rules in modular arithmetic
   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         mq = 0; mm = DM; mrun = 0; mdone = 0; mtgl = 0;
      end else begin
         int g, c;
         g = model_gate();
         c = model_co();
         mdone = 0;
         if (CLR) begin
            mq = 0; mrun = 0; mtgl = 0;
         end else begin
            if (mrun != 0) begin
               if (!ONESHOT)   mrun = 0;
               else if (c != 0) begin mrun = 0; mdone = 1; end
            end else if (START && ONESHOT) begin
               mrun = 1;
            end
            if (c != 0) mtgl = 1 - mtgl;
            if (MOD_WE && int'(MOD_D) != 0) begin
               mm = int'(MOD_D);
               mq = DIR ? mm - 1 : 0;
            end else if (LOAD) begin
               mq = (int'(D) < mm) ? int'(D) : mm - 1;
            end else if (g != 0) begin
               mq = DIR ? (mq + mm - 1) % mm : (mq + 1) % mm;
            end
         end
      end
   end

   // per-cycle comparison against the model
   always @(negedge CLK) begin
      check("q",    int'(Q),    mq);
      check("co",   int'(CO),   model_co());
      check("busy", int'(BUSY), (mrun != 0 && ONESHOT) ? 1 : 0);
      check("done", int'(DONE), mdone);
`ifdef MOD_COUNTER_PROG_TOGGLE_EN
      check("tgl",  int'(TGL),  mtgl);
`else
      check("tgl",  int'(TGL),  0);
`endif
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int highs;
      RST_N = 1'b0; CE = 1'b0; CLR = 1'b0; LOAD = 1'b0; MOD_WE = 1'b0;
      DIR = 1'b0; ONESHOT = 1'b0; START = 1'b0; D = '0; MOD_D = '0;
      #3;
      check("rst_q",    int'(Q),    0);
      check("rst_busy", int'(BUSY), 0);
      check("rst_done", int'(DONE), 0);
      check("rst_tgl",  int'(TGL),  0);
      #10;
      RST_N = 1'b1;
      CE    = 1'b1;
      #1;
      check("free_q0",  int'(Q),  0);
      check("free_co0", int'(CO), 0);
      // free-running up count, M=5
      for (int i = 1; i <= 5; i++) begin
         step();
         check("free_q",  int'(Q),  i % 5);
         check("free_co", int'(CO), (i % 5 == 4) ? 1 : 0);
      end

      // modulo write 3, counting down
      MOD_WE = 1'b1; MOD_D = 4'd3; DIR = 1'b1;
      step();
      MOD_WE = 1'b0;
      check("modwr_q", int'(Q), 2);
      step(); check("down_q1", int'(Q), 1);
      step(); check("down_q0", int'(Q), 0); check("down_co", int'(CO), 1);
      step(); check("down_wrap", int'(Q), 2);
      // zero modulo write is ignored and counting proceeds
      MOD_WE = 1'b1; MOD_D = 4'd0;
      step();
      MOD_WE = 1'b0;
      check("modwr0_q", int'(Q), 1);
      step(); check("modwr0_q0", int'(Q), 0);
      step(); check("modwr0_wrap", int'(Q), 2);
      // direction flip at Q=2 with M=3 lands on the up terminal
      DIR = 1'b0;
      #1 check("dirflip_co", int'(CO), 1);
      step(); check("dirflip_q", int'(Q), 0);

      // load clamp and clear priority, M=5
      MOD_WE = 1'b1; MOD_D = 4'd5;
      step();
      MOD_WE = 1'b0;
      check("mod5_q", int'(Q), 0);
      LOAD = 1'b1; D = 4'd9;
      step(); check("load_clamp", int'(Q), 4);
      D = 4'd2; CLR = 1'b1;
      step(); check("load_clr", int'(Q), 0);
      CLR = 1'b0; D = 4'd3;
      step(); check("load_q", int'(Q), 3);
      LOAD = 1'b0;

      // one-shot run, M=4
      MOD_WE = 1'b1; MOD_D = 4'd4;
      step();
      MOD_WE = 1'b0; CE = 1'b0; ONESHOT = 1'b1;
      step(); step();
      check("idle_hold", int'(Q), 0);
      CE = 1'b1; START = 1'b1;
      step();
      START = 1'b0;
      check("os_busy", int'(BUSY), 1);
      check("os_q0",   int'(Q),    0);
      step(); check("os_q1", int'(Q), 1);
      START = 1'b1;
      step(); check("os_q2", int'(Q), 2);
      START = 1'b0;
      step(); check("os_q3", int'(Q), 3); check("os_co", int'(CO), 1);
      check("os_busy3", int'(BUSY), 1);
      step();
      check("os_end_q",    int'(Q),    0);
      check("os_end_busy", int'(BUSY), 0);
      check("os_end_done", int'(DONE), 1);
      step();
      check("os_done_off", int'(DONE), 0);
      check("os_idle_q",   int'(Q),    0);

      // asynchronous reset in the middle of a run
      START = 1'b1;
      step();
      START = 1'b0;
      step(); step();
      check("mid_q",    int'(Q),    2);
      check("mid_busy", int'(BUSY), 1);
      #2 RST_N = 1'b0;
      #1;
      check("arst_q",    int'(Q),    0);
      check("arst_busy", int'(BUSY), 0);
      RST_N = 1'b1; ONESHOT = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         step();
         check("post_q",  int'(Q),  i % 5);
         check("post_co", int'(CO), (i % 5 == 4) ? 1 : 0);
      end

      // divided square output with M=3
      CLR = 1'b1;
      step();
      CLR = 1'b0; MOD_WE = 1'b1; MOD_D = 4'd3;
      step();
      MOD_WE = 1'b0;
      highs = 0;
      for (int k = 1; k <= 12; k++) begin
         step();
         highs += int'(TGL);
`ifdef MOD_COUNTER_PROG_TOGGLE_EN
         check("tgl_seq", int'(TGL), (k / 3) % 2);
`endif
      end
`ifdef MOD_COUNTER_PROG_TOGGLE_EN
      check("tgl_highs", highs, 6);
`else
      check("tgl_highs", highs, 0);
`endif

      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
